imm_ext_agu: RTL and testbench
==============================

// Module: imm_ext_agu
// PURPOSE
//   Pipelined immediate-extension and address-generation unit for the MIPS datapath.
//   Extends an IMM_W-bit instruction immediate per a mode select and, for memory ops, adds it to a base register.
//   2-stage valid/ready pipeline between decode and execute/memory; one result per cycle sustained.
// PARAMETERS
//   DATA_W  32  datapath/address width; must satisfy DATA_W > IMM_W+2
//   IMM_W   16  immediate field width
// PORTS
//   clk          in   1        rising-edge clock
//   rst          in   1        asynchronous reset, active-high
//   in_valid     in   1        request valid
//   in_ready     out  1        unit accepts request this cycle
//   imm          in   IMM_W    raw immediate
//   mode         in   2        00 SEXT, 01 ZEXT, 10 UPPER, 11 BRANCH
//   base         in   DATA_W   base register value (rs)
//   is_mem       in   1        1: out_addr = base + ext; 0: out_addr = ext
//   size         in   2        access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
//   out_valid    out  1        result valid
//   out_ready    in   1        consumer accepts result
//   out_ext      out  DATA_W   extended immediate
//   out_addr     out  DATA_W   effective address / pass-through value
//   out_misalign out  1        misaligned access flag (ALIGN_CHECK_EN only)
// BEHAVIOUR
//   Extension (stage A, combinational in, registered out):
//   - SEXT: replicate imm[IMM_W-1] into the upper DATA_W-IMM_W bits.
//   - ZEXT: upper bits zero.
//   - UPPER: {imm, (DATA_W-IMM_W) zeros}.
//   - BRANCH: SEXT value shifted left by 2; the top 2 bits are discarded.
//   Addition (stage B): out_addr = is_mem ? base+ext : ext. Modulo 2^DATA_W, wraps silently, no carry out.
//   Handshake:
//   - Transfer occurs on valid&&ready at a rising edge.
//   - Inputs must hold stable while in_valid && !in_ready.
//   - Outputs hold stable while out_valid && !out_ready.
//   Pipeline:
//   - Stage A accepts when empty or advancing into B.
//   - B advances when empty or out_ready.
//   - in_ready = !a_vld || (!b_vld || out_ready); combinational from out_ready, no bubble.
//   - Latency: accept at edge N -> out_valid at edge N+2 when unstalled.
//   - Full stall: both stages hold and in_ready=0; no data lost or duplicated.
//   - Simultaneous accept and drain in the same cycle is legal and keeps 1/cycle throughput.
//   Reset:
//   - a_vld, b_vld, out_valid, out_misalign reset to 0; out_ext and out_addr reset to 0.
//   - Reset mid-operation discards in-flight entries; nothing is emitted after reset release until a new accept.
//   is_mem=0: size is ignored and out_misalign=0.
// CONFIGURATION
//   ALIGN_CHECK_EN defined:
//   - out_misalign registered with out_addr, set when is_mem and (half && addr[0]) or (word/reserved && addr[1:0]!=0).
//   - The result is still delivered; the flag is advisory to the trap logic.
//   ALIGN_CHECK_EN undefined: out_misalign is tied to 0 and no check logic is built.
// STRUCTURE
//   Package agu_pkg:
//   - mode encodings AGU_SEXT/AGU_ZEXT/AGU_UPPER/AGU_BRANCH
//   - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
//   - function align_ok(size, addr_lsb)
//   Sub-module imm_extender: purely combinational mode -> ext, parametrised DATA_W/IMM_W.
//   Top holds both pipeline registers, handshake logic, and the adder.
// TESTING (DATA_W=32, IMM_W=16)
//   1. imm=16'h8004, SEXT, is_mem=0 -> out_ext=out_addr=32'hFFFF8004 two cycles after accept.
//   2. imm=16'h8004: ZEXT -> 32'h00008004; UPPER -> 32'h80040000; BRANCH -> 32'hFFFE0010.
//   3. base=32'hFFFFFFF0, imm=16'h0020, SEXT, is_mem=1 -> out_addr=32'h00000010 (wrap).
//   4. Stream 8 back-to-back requests, out_ready low for cycles 3-6:
//      -> in_ready drops after 2 buffered; all 8 results in order; no drops or duplicates.
//   5. With ALIGN_CHECK_EN: base=32'h1000, imm=2, word -> out_misalign=1; half -> 0; byte imm=3 -> 0.
//   6. Assert rst with both stages full -> out_valid=0 immediately; after release first out_valid only 2 cycles after a new accept.

Source files
------------

// File: rtl/agu_pkg.sv
// Shared encodings and the alignment helper for the immediate-extension / address-generation unit.
package agu_pkg;

    typedef enum logic [1:0] {
        AGU_SEXT   = 2'b00,
        AGU_ZEXT   = 2'b01,
        AGU_UPPER  = 2'b10,
        AGU_BRANCH = 2'b11
    } agu_mode_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } agu_size_e;

    // Reserved size is handled like a word access.
    function automatic logic align_ok(input logic [1:0] size, input logic [1:0] addr_lsb);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr_lsb[0];
            default: ok = (addr_lsb == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/imm_extender.sv
// Purpose: combinational immediate extension selected by mode (SEXT/ZEXT/UPPER/BRANCH).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the enclosing pipeline owns all flow control.
module imm_extender
    import agu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] ext
);

    logic [DATA_W-1:0] sext;

    assign sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    always_comb begin
        ext = sext;
        case (mode)
            AGU_SEXT:   ext = sext;
            AGU_ZEXT:   ext = {{(DATA_W-IMM_W){1'b0}}, imm};
            AGU_UPPER:  ext = {imm, {(DATA_W-IMM_W){1'b0}}};
            AGU_BRANCH: ext = {sext[DATA_W-3:0], 2'b00};
            default:    ext = sext;
        endcase
    end

endmodule

// File: rtl/imm_ext_agu.sv
// Purpose: 2-stage valid/ready immediate extension + address generation; ALIGN_CHECK_EN adds a misalign flag.
// Latency: accept at edge N, out_valid high after edge N+1, so the result transfers at edge N+2 at the earliest.
// Backpressure: in_ready = !a_vld || !b_vld || out_ready (combinational, no bubble); both stages hold when stalled.
module imm_ext_agu
    import agu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] base,
    input  logic              is_mem,
    input  logic [1:0]        size,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_ext,
    output logic [DATA_W-1:0] out_addr,
    output logic              out_misalign
);

    logic              a_vld_q, a_vld_d;
    logic [DATA_W-1:0] a_ext_q, a_ext_d;
    logic [DATA_W-1:0] a_base_q, a_base_d;
    logic              a_mem_q, a_mem_d;
    logic              b_vld_q, b_vld_d;
    logic [DATA_W-1:0] b_ext_q, b_ext_d;
    logic [DATA_W-1:0] b_addr_q, b_addr_d;

    logic [DATA_W-1:0] ext_w;
    logic [DATA_W-1:0] sum_w;
    logic              b_adv;
    logic              a_acc;
    logic              b_load;

    imm_extender #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_ext (
        .imm  (imm),
        .mode (mode),
        .ext  (ext_w)
    );

    assign b_adv    = !b_vld_q || out_ready;
    assign in_ready = !a_vld_q || b_adv;
    assign a_acc    = in_valid && in_ready;
    assign b_load   = b_adv && a_vld_q;
    assign sum_w    = a_mem_q ? (a_base_q + a_ext_q) : a_ext_q;

    always_comb begin
        a_vld_d  = a_vld_q;
        a_ext_d  = a_ext_q;
        a_base_d = a_base_q;
        a_mem_d  = a_mem_q;
        b_vld_d  = b_vld_q;
        b_ext_d  = b_ext_q;
        b_addr_d = b_addr_q;
        // A can only accept while stalled if it is empty, so draining into B cannot lose it.
        if (a_acc) begin
            a_vld_d  = 1'b1;
            a_ext_d  = ext_w;
            a_base_d = base;
            a_mem_d  = is_mem;
        end else if (b_adv) begin
            a_vld_d  = 1'b0;
        end
        if (b_adv) begin
            b_vld_d = a_vld_q;
        end
        if (b_load) begin
            b_ext_d  = a_ext_q;
            b_addr_d = sum_w;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_vld_q  <= 1'b0;
            a_ext_q  <= '0;
            a_base_q <= '0;
            a_mem_q  <= 1'b0;
            b_vld_q  <= 1'b0;
            b_ext_q  <= '0;
            b_addr_q <= '0;
        end else begin
            a_vld_q  <= a_vld_d;
            a_ext_q  <= a_ext_d;
            a_base_q <= a_base_d;
            a_mem_q  <= a_mem_d;
            b_vld_q  <= b_vld_d;
            b_ext_q  <= b_ext_d;
            b_addr_q <= b_addr_d;
        end
    end

`ifdef ALIGN_CHECK_EN
    logic [1:0] a_size_q;
    logic       b_mis_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_size_q <= 2'b00;
            b_mis_q  <= 1'b0;
        end else begin
            if (a_acc) a_size_q <= size;
            if (b_load) b_mis_q <= a_mem_q && !align_ok(a_size_q, sum_w[1:0]);
        end
    end

    assign out_misalign = b_mis_q;
`else
    logic unused_size;
    assign unused_size  = ^size;
    assign out_misalign = 1'b0;
`endif

    assign out_valid = b_vld_q;
    assign out_ext   = b_ext_q;
    assign out_addr  = b_addr_q;

endmodule

// File: tb/tb_imm_ext_agu.sv
// Directed + randomized bench for imm_ext_agu with a queue-based reference model; ALIGN_CHECK_EN selects flag expectations.
module tb_imm_ext_agu;

    typedef struct {
        logic [31:0] ext;
        logic [31:0] addr;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] base;
    logic        is_mem;
    logic [1:0]  size;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ext;
    logic [31:0] out_addr;
    logic        out_misalign;

    int   checks   = 0;
    int   failures = 0;
    int   npop     = 0;
    exp_t q[$];
    logic        held = 1'b0;
    logic [31:0] held_ext, held_addr;
    logic        held_mis;

    imm_ext_agu #(.DATA_W(32), .IMM_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imm          (imm),
        .mode         (mode),
        .base         (base),
        .is_mem       (is_mem),
        .size         (size),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ext      (out_ext),
        .out_addr     (out_addr),
        .out_misalign (out_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: arithmetic on the immediate's numeric value, modulo 2^32.
    function automatic exp_t model(input logic [15:0] im, input logic [1:0] md,
                                   input logic [31:0] bs, input logic mem, input logic [1:0] sz);
        exp_t r;
        int   s;
        s = (im >= 16'h8000) ? (int'(im) - 65536) : int'(im);
        case (md)
            2'd0:    r.ext = 32'(s);
            2'd1:    r.ext = 32'(im);
            2'd2:    r.ext = 32'(im) * 32'd65536;
            default: r.ext = 32'(s * 4);
        endcase
        r.addr = mem ? (bs + r.ext) : r.ext;
`ifdef ALIGN_CHECK_EN
        r.mis = mem && (((sz == 2'd1) && (r.addr % 2 != 0)) || ((sz >= 2'd2) && (r.addr % 4 != 0)));
`else
        r.mis = 1'b0;
        if (sz == 2'd3) r.mis = 1'b0;
`endif
        return r;
    endfunction

    // One clock: observe handshakes at negedge, let the edge happen, return at posedge+1.
    task automatic cycle();
        logic acc;
        exp_t e;
        @(negedge clk);
        if (held) begin
            chk("hold_ext", out_ext, held_ext);
            chk("hold_addr", out_addr, held_addr);
            chk("hold_mis", {31'b0, out_misalign}, {31'b0, held_mis});
        end
        held      = out_valid && !out_ready;
        held_ext  = out_ext;
        held_addr = out_addr;
        held_mis  = out_misalign;
        acc = in_valid && in_ready;
        if (acc) q.push_back(model(imm, mode, base, is_mem, size));
        if (out_valid && out_ready) begin
            npop++;
            if (q.size() == 0) begin
                chk("spurious_out", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("model_ext", out_ext, e.ext);
                chk("model_addr", out_addr, e.addr);
                chk("model_mis", {31'b0, out_misalign}, {31'b0, e.mis});
            end
        end
        @(posedge clk);
        #1;
        if (acc) in_valid = 1'b0;
    endtask

    task automatic set_req(input logic [15:0] im, input logic [1:0] md,
                           input logic [31:0] bs, input logic mem, input logic [1:0] sz);
        imm = im; mode = md; base = bs; is_mem = mem; size = sz;
        in_valid = 1'b1;
    endtask

    // Send one request into an empty pipe and compare the emerging result with constants.
    task automatic send_wait(input string tag, input logic [15:0] im, input logic [1:0] md,
                             input logic [31:0] bs, input logic mem, input logic [1:0] sz,
                             input logic [31:0] e_ext, input logic [31:0] e_addr, input logic e_mis);
        int n = 0;
        set_req(im, md, bs, mem, sz);
        out_ready = 1'b1;
        cycle();
        while (!out_valid && n < 10) begin
            cycle();
            n++;
        end
        chk({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_ext"}, out_ext, e_ext);
        chk({tag, "_addr"}, out_addr, e_addr);
        chk({tag, "_mis"}, {31'b0, out_misalign}, {31'b0, e_mis});
        cycle();
    endtask

    initial begin
        int   sent;
        logic saw_block;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        imm = '0; mode = '0; base = '0; is_mem = 1'b0; size = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_ext", out_ext, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_misalign", {31'b0, out_misalign}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Latency: accept at edge N, valid after edge N+1.
        set_req(16'h8004, 2'b00, 32'h0, 1'b0, 2'b10);
        cycle();
        chk("lat_after_n", {31'b0, out_valid}, 32'd0);
        cycle();
        chk("lat_after_n1", {31'b0, out_valid}, 32'd1);
        chk("sext_ext", out_ext, 32'hFFFF8004);
        chk("sext_addr", out_addr, 32'hFFFF8004);
        cycle();

        send_wait("zext", 16'h8004, 2'b01, 32'h0, 1'b0, 2'b00, 32'h00008004, 32'h00008004, 1'b0);
        send_wait("upper", 16'h8004, 2'b10, 32'h0, 1'b0, 2'b00, 32'h80040000, 32'h80040000, 1'b0);
        send_wait("branch", 16'h8004, 2'b11, 32'h0, 1'b0, 2'b00, 32'hFFFE0010, 32'hFFFE0010, 1'b0);
        send_wait("wrap", 16'h0020, 2'b00, 32'hFFFFFFF0, 1'b1, 2'b00, 32'h00000020, 32'h00000010, 1'b0);
`ifdef ALIGN_CHECK_EN
        send_wait("al_word", 16'h0002, 2'b00, 32'h1000, 1'b1, 2'b10, 32'h2, 32'h1002, 1'b1);
        send_wait("al_half", 16'h0002, 2'b00, 32'h1000, 1'b1, 2'b01, 32'h2, 32'h1002, 1'b0);
        send_wait("al_byte", 16'h0003, 2'b00, 32'h1000, 1'b1, 2'b00, 32'h3, 32'h1003, 1'b0);
`else
        send_wait("al_word", 16'h0002, 2'b00, 32'h1000, 1'b1, 2'b10, 32'h2, 32'h1002, 1'b0);
`endif

        // Back-to-back stream of 8 with out_ready low for cycles 3..6.
        npop = 0; sent = 0; saw_block = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!in_valid && sent < 8) begin
                set_req(16'($urandom), 2'($urandom), $urandom, 1'($urandom), 2'($urandom));
                sent++;
            end
            out_ready = !(c >= 3 && c <= 6);
            if (!in_ready) saw_block = 1'b1;
            cycle();
        end
        chk("stream_count", 32'(npop), 32'd8);
        chk("stream_blocked", {31'b0, saw_block}, 32'd1);
        chk("stream_empty", 32'(q.size()), 32'd0);

        // Random traffic with random backpressure.
        npop = 0; sent = 0;
        for (int c = 0; c < 300; c++) begin
            if (!in_valid && ($urandom_range(0, 3) != 0)) begin
                set_req(16'($urandom), 2'($urandom), $urandom, 1'($urandom), 2'($urandom));
                sent++;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && (in_valid || q.size() != 0); c++) cycle();
        chk("rand_count", 32'(npop), 32'(sent));
        chk("rand_empty", 32'(q.size()), 32'd0);

        // Reset with both stages full.
        out_ready = 1'b0;
        set_req(16'h1111, 2'b01, 32'h0, 1'b0, 2'b00);
        cycle();
        set_req(16'h2222, 2'b01, 32'h0, 1'b0, 2'b00);
        cycle();
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        chk("full_out_valid", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_ext", out_ext, 32'd0);
        chk("rst_mid_addr", out_addr, 32'd0);
        q.delete();
        held = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk("post_rst_idle", {31'b0, out_valid}, 32'd0);
        end
        set_req(16'h0040, 2'b00, 32'h100, 1'b1, 2'b10);
        cycle();
        chk("post_rst_n", {31'b0, out_valid}, 32'd0);
        cycle();
        chk("post_rst_n1", {31'b0, out_valid}, 32'd1);
        chk("post_rst_addr", out_addr, 32'h140);
        cycle();
        chk("post_rst_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
